// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : shares the LC-3b memory port between CPU and DMA masters.
// Build option MEM_ARB_RR_EN: round-robin tie-break (default: CPU priority).
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int AW      = 16,
  parameter int DW      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_ack,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          owner,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [3:0] CNT_LOAD  = 4'(MEM_LAT - 1);
  localparam logic       ONE_CYCLE = (MEM_LAT == 1) ? 1'b1 : 1'b0;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          lat_we_q, lat_we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          owner_q, owner_d;
  logic          last_owner_q, last_owner_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] dma_rdata_q, dma_rdata_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          dma_ack_q, dma_ack_d;
  logic          busy_q, busy_d;
  logic          grant_dma;

`ifdef MEM_ARB_RR_EN
  // On a tie the master that did not win last time is served.
  assign grant_dma = dma_req & (~cpu_req | ~last_owner_q);
`else
  // Grant history is tracked in both builds; fixed priority never consults it.
  logic last_owner_unused;
  assign last_owner_unused = last_owner_q;
  assign grant_dma = dma_req & ~cpu_req;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lat_we_d     = lat_we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    cpu_ack_d    = 1'b0;
    dma_ack_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (cpu_req || dma_req) begin
          owner_d      = grant_dma;
          last_owner_d = grant_dma;
          lat_we_d     = grant_dma ? dma_we    : cpu_we;
          addr_d       = grant_dma ? dma_addr  : cpu_addr;
          wdata_d      = grant_dma ? dma_wdata : cpu_wdata;
          cnt_d        = CNT_LOAD;
          state_d      = ACCESS;
          mem_en_d     = 1'b1;
          mem_we_d     = ONE_CYCLE & lat_we_d;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d   = RESP;
          cpu_ack_d = ~owner_q;
          dma_ack_d = owner_q;
          if (!lat_we_q) begin
            if (owner_q) dma_rdata_d = mem_rdata;
            else         cpu_rdata_d = mem_rdata;
          end
        end else begin
          // Output flops are loaded one cycle ahead, so the strobe for the
          // final ACCESS cycle is decided while cnt is still 1.
          cnt_d    = cnt_q - 4'd1;
          mem_en_d = 1'b1;
          mem_we_d = lat_we_q & (cnt_q == 4'd1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      lat_we_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      cpu_ack_q    <= 1'b0;
      dma_ack_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lat_we_q     <= lat_we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      cpu_ack_q    <= cpu_ack_d;
      dma_ack_q    <= dma_ack_d;
      busy_q       <= busy_d;
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign dma_ack   = dma_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign owner     = owner_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter : directed per-cycle vectors plus a tie/fairness sequence.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  localparam int MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;
  logic        cpu_ack, dma_ack, mem_en, mem_we, owner, busy;
  logic [15:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;

  int vectors     = 0;
  int miscompares = 0;

  mem_port_arbiter #(.MEM_LAT(MEM_LAT), .AW(16), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        creq, cwe;
    logic [15:0] caddr, cwd;
    logic        dreq, dwe;
    logic [15:0] daddr, dwd, mrd;
    logic        en, we;
    logic [15:0] addr, wd;
    logic        cack, dack;
    logic [15:0] crd, drd;
    logic        own, bsy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t row(
    input logic rst, input logic creq, input logic cwe, input logic [15:0] caddr,
    input logic [15:0] cwd, input logic dreq, input logic dwe, input logic [15:0] daddr,
    input logic [15:0] dwd, input logic [15:0] mrd,
    input logic en, input logic we, input logic [15:0] addr, input logic [15:0] wd,
    input logic cack, input logic dack, input logic [15:0] crd, input logic [15:0] drd,
    input logic own, input logic bsy);
    vec_t v;
    v.rst = rst;   v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
    v.dreq = dreq; v.dwe = dwe;   v.daddr = daddr; v.dwd = dwd; v.mrd = mrd;
    v.en = en;     v.we = we;     v.addr = addr;   v.wd = wd;
    v.cack = cack; v.dack = dack; v.crd = crd;     v.drd = drd;
    v.own = own;   v.bsy = bsy;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    rst_n     = v.rst;
    cpu_req   = v.creq; cpu_we = v.cwe; cpu_addr = v.caddr; cpu_wdata = v.cwd;
    dma_req   = v.dreq; dma_we = v.dwe; dma_addr = v.daddr; dma_wdata = v.dwd;
    mem_rdata = v.mrd;
  endtask

  task automatic check_row(input int i, input vec_t v);
    vectors++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, cpu_ack, dma_ack, cpu_rdata, dma_rdata, owner, busy} !==
        {v.en, v.we, v.addr, v.wd, v.cack, v.dack, v.crd, v.drd, v.own, v.bsy}) begin
      miscompares++;
      $display("FAIL row%0d: got en=%b we=%b addr=%h wd=%h cack=%b dack=%b crd=%h drd=%h own=%b busy=%b; want en=%b we=%b addr=%h wd=%h cack=%b dack=%b crd=%h drd=%h own=%b busy=%b",
               i, mem_en, mem_we, mem_addr, mem_wdata, cpu_ack, dma_ack, cpu_rdata, dma_rdata, owner, busy,
               v.en, v.we, v.addr, v.wd, v.cack, v.dack, v.crd, v.drd, v.own, v.bsy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic exp_own [4];
    logic got_own [4];
    int   ack_cyc [4];
    int   n;
    int   cyc;

    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0; mem_rdata = '0;

    //               rst creq cwe caddr     cwd       dreq dwe daddr     dwd       mrd         en we addr      wd        ca da crd       drd       own bsy
    // Reset with both requests high, then tie goes to CPU (CPU read), then DMA write.
    tbl.push_back(row(0, 1, 0, 16'h3000, 16'h0000, 1, 1, 16'h4000, 16'hBEEF, 16'hDEAD, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0));
    tbl.push_back(row(0, 1, 0, 16'h3000, 16'h0000, 1, 1, 16'h4000, 16'hBEEF, 16'hDEAD, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0));
    tbl.push_back(row(1, 1, 0, 16'h3000, 16'h0000, 1, 1, 16'h4000, 16'hBEEF, 16'hDEAD, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0));
    tbl.push_back(row(1, 1, 0, 16'h3000, 16'h0000, 1, 1, 16'h4000, 16'hBEEF, 16'hDEAD, 1, 0, 16'h3000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 1));
    tbl.push_back(row(1, 1, 0, 16'h3000, 16'h0000, 1, 1, 16'h4000, 16'hBEEF, 16'h1234, 1, 0, 16'h3000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 1));
    tbl.push_back(row(1, 1, 0, 16'h3000, 16'h0000, 1, 1, 16'h4000, 16'hBEEF, 16'hDEAD, 0, 0, 16'h3000, 16'h0000, 1, 0, 16'h1234, 16'h0000, 0, 1));
    tbl.push_back(row(1, 0, 0, 16'h3000, 16'h0000, 1, 1, 16'h4000, 16'hBEEF, 16'hDEAD, 0, 0, 16'h3000, 16'h0000, 0, 0, 16'h1234, 16'h0000, 0, 0));
    tbl.push_back(row(1, 0, 0, 16'h3000, 16'h0000, 1, 1, 16'h4000, 16'hBEEF, 16'hDEAD, 1, 0, 16'h4000, 16'hBEEF, 0, 0, 16'h1234, 16'h0000, 1, 1));
    tbl.push_back(row(1, 0, 0, 16'h3000, 16'h0000, 1, 1, 16'h4000, 16'hBEEF, 16'h5555, 1, 1, 16'h4000, 16'hBEEF, 0, 0, 16'h1234, 16'h0000, 1, 1));
    tbl.push_back(row(1, 0, 0, 16'h3000, 16'h0000, 1, 1, 16'h4000, 16'hBEEF, 16'hDEAD, 0, 0, 16'h4000, 16'hBEEF, 0, 1, 16'h1234, 16'h0000, 1, 1));
    tbl.push_back(row(1, 0, 0, 16'h3000, 16'h0000, 0, 0, 16'h4000, 16'hBEEF, 16'hDEAD, 0, 0, 16'h4000, 16'hBEEF, 0, 0, 16'h1234, 16'h0000, 1, 0));
    // DMA read captures into dma_rdata only.
    tbl.push_back(row(1, 0, 0, 16'h3000, 16'h0000, 1, 0, 16'h4002, 16'h0000, 16'hDEAD, 0, 0, 16'h4000, 16'hBEEF, 0, 0, 16'h1234, 16'h0000, 1, 0));
    tbl.push_back(row(1, 0, 0, 16'h3000, 16'h0000, 1, 0, 16'h4002, 16'h0000, 16'hDEAD, 1, 0, 16'h4002, 16'h0000, 0, 0, 16'h1234, 16'h0000, 1, 1));
    tbl.push_back(row(1, 0, 0, 16'h3000, 16'h0000, 1, 0, 16'h4002, 16'h0000, 16'hABCD, 1, 0, 16'h4002, 16'h0000, 0, 0, 16'h1234, 16'h0000, 1, 1));
    tbl.push_back(row(1, 0, 0, 16'h3000, 16'h0000, 1, 0, 16'h4002, 16'h0000, 16'hDEAD, 0, 0, 16'h4002, 16'h0000, 0, 1, 16'h1234, 16'hABCD, 1, 1));
    // CPU write aborted by reset in its first ACCESS cycle.
    tbl.push_back(row(1, 1, 1, 16'h5000, 16'h7777, 0, 0, 16'h4002, 16'h0000, 16'hDEAD, 0, 0, 16'h4002, 16'h0000, 0, 0, 16'h1234, 16'hABCD, 1, 0));
    tbl.push_back(row(0, 1, 1, 16'h5000, 16'h7777, 0, 0, 16'h4002, 16'h0000, 16'hDEAD, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0));
    tbl.push_back(row(1, 0, 0, 16'h5000, 16'h7777, 0, 0, 16'h4002, 16'h0000, 16'hDEAD, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0));
    // Back-to-back CPU reads: re-request on the ack edge.
    tbl.push_back(row(1, 1, 0, 16'h6000, 16'h0000, 0, 0, 16'h4002, 16'h0000, 16'hDEAD, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0));
    tbl.push_back(row(1, 1, 0, 16'h6000, 16'h0000, 0, 0, 16'h4002, 16'h0000, 16'hDEAD, 1, 0, 16'h6000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 1));
    tbl.push_back(row(1, 1, 0, 16'h6000, 16'h0000, 0, 0, 16'h4002, 16'h0000, 16'h0042, 1, 0, 16'h6000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 1));
    tbl.push_back(row(1, 1, 0, 16'h6000, 16'h0000, 0, 0, 16'h4002, 16'h0000, 16'hDEAD, 0, 0, 16'h6000, 16'h0000, 1, 0, 16'h0042, 16'h0000, 0, 1));
    tbl.push_back(row(1, 1, 0, 16'h6002, 16'h0000, 0, 0, 16'h4002, 16'h0000, 16'hDEAD, 0, 0, 16'h6000, 16'h0000, 0, 0, 16'h0042, 16'h0000, 0, 0));
    tbl.push_back(row(1, 1, 0, 16'h6002, 16'h0000, 0, 0, 16'h4002, 16'h0000, 16'hDEAD, 1, 0, 16'h6002, 16'h0000, 0, 0, 16'h0042, 16'h0000, 0, 1));
    tbl.push_back(row(1, 1, 0, 16'h6002, 16'h0000, 0, 0, 16'h4002, 16'h0000, 16'h0099, 1, 0, 16'h6002, 16'h0000, 0, 0, 16'h0042, 16'h0000, 0, 1));
    tbl.push_back(row(1, 1, 0, 16'h6002, 16'h0000, 0, 0, 16'h4002, 16'h0000, 16'hDEAD, 0, 0, 16'h6002, 16'h0000, 1, 0, 16'h0099, 16'h0000, 0, 1));
    tbl.push_back(row(1, 0, 0, 16'h6002, 16'h0000, 0, 0, 16'h4002, 16'h0000, 16'hDEAD, 0, 0, 16'h6002, 16'h0000, 0, 0, 16'h0099, 16'h0000, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      apply(tbl[i]);
      @(negedge clk);
      check_row(i, tbl[i]);
    end

    // Both masters request continuously from reset: check grant order and spacing.
`ifdef MEM_ARB_RR_EN
    exp_own[0] = 1'b0; exp_own[1] = 1'b1; exp_own[2] = 1'b0; exp_own[3] = 1'b1;
`else
    exp_own[0] = 1'b0; exp_own[1] = 1'b0; exp_own[2] = 1'b0; exp_own[3] = 1'b0;
`endif
    @(posedge clk); #1;
    rst_n = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h7000;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h8000;
    mem_rdata = 16'h0F0F;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n = 0;
    cyc = 0;
    while (n < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (cpu_ack && dma_ack) begin
        vectors++;
        miscompares++;
        $display("FAIL both_acks: got cpu_ack=1 dma_ack=1 at cycle %0d, want at most one", cyc);
      end
      if (cpu_ack || dma_ack) begin
        got_own[n] = dma_ack;
        ack_cyc[n] = cyc;
        n++;
      end
    end
    if (n < 4) begin
      vectors++;
      miscompares++;
      $display("FAIL tie_timeout: got %0d acks, want 4", n);
    end
    if (n > 0) begin
      vectors++;
      if (ack_cyc[0] != MEM_LAT + 2) begin
        miscompares++;
        $display("FAIL first_ack_latency: got cycle %0d, want %0d", ack_cyc[0], MEM_LAT + 2);
      end
    end
    for (int k = 0; k < n; k++) begin
      vectors++;
      if (got_own[k] !== exp_own[k]) begin
        miscompares++;
        $display("FAIL tie_order[%0d]: got ack to %s, want %s", k,
                 got_own[k] ? "DMA" : "CPU", exp_own[k] ? "DMA" : "CPU");
      end
      if (k > 0) begin
        vectors++;
        if (ack_cyc[k] - ack_cyc[k-1] != MEM_LAT + 2) begin
          miscompares++;
          $display("FAIL tie_spacing[%0d]: got %0d cycles, want %0d", k,
                   ack_cyc[k] - ack_cyc[k-1], MEM_LAT + 2);
        end
      end
    end
    cpu_req = 1'b0;
    dma_req = 1'b0;
    repeat (6) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares the single LC-3b memory port between two requesters:
  - the multicycle controller's fetch/load/store path (CPU);
  - a program-loader/DMA port (DMA).
- Serializes accesses through a fixed-latency memory using a 3-state FSM with a req/ack handshake, and drives the memory enable, write strobe, address and write data.
- Sits between the controller/datapath and the memory block.

## Interface

Parameters:
- MEM_LAT, 2, memory access cycles per transaction (legal 1..15)
- AW, 16, address width
- DW, 16, data width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_we  in  1  CPU write (1) / read (0)
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_ack  out  1  one-cycle completion pulse to CPU
- cpu_rdata  out  DW  last CPU read data, registered
- dma_req, dma_we, dma_addr, dma_wdata  in  1/1/AW/DW  DMA equivalents
- dma_ack  out  1  one-cycle completion pulse to DMA
- dma_rdata  out  DW  last DMA read data, registered
- mem_en  out  1  memory access active
- mem_we  out  1  memory write strobe
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid in last ACCESS cycle
- owner  out  1  current/last grantee: 0 = CPU, 1 = DMA
- busy  out  1  high whenever state != IDLE

## Operation

FSM states: IDLE, ACCESS, RESP.

- **IDLE**
  - Samples cpu_req/dma_req.
  - With no request, stays in IDLE.
  - Otherwise selects a winner and latches its we/addr/wdata into internal registers.
  - Sets owner, loads cnt = MEM_LAT-1, and moves to ACCESS.
- **ACCESS**
  - mem_en = 1; mem_addr/mem_wdata come from the latched registers.
  - mem_we = 1 only in the final ACCESS cycle (cnt == 0), and only for writes.
  - cnt decrements each cycle.
  - When cnt == 0:
    - on a read, mem_rdata is captured into the owner's rdata register at that edge;
    - the FSM moves to RESP.
- **RESP**
  - The owner's ack is high for exactly this one cycle; the other ack stays 0.
  - Next state is always IDLE.
- Arbitration:
  - A single requester always wins.
  - When both request, the winner is set by the configuration macro (see Configuration).
  - last_owner updates on every grant.
- Data registers:
  - A write leaves both rdata registers unchanged.
  - cpu_rdata/dma_rdata change only on a read completion by that requester.
- Outputs outside ACCESS:
  - mem_addr/mem_wdata keep their last latched values.
  - mem_en = mem_we = 0.
- Requests are not re-examined during ACCESS/RESP. If req drops mid-transaction, the transaction still completes and the ack is still issued.
- Reset (rst_n low, any state, takes effect immediately):
  - state = IDLE; mem_en, mem_we, cpu_ack, dma_ack, busy = 0;
  - mem_addr, mem_wdata, cpu_rdata, dma_rdata = 0;
  - owner = 0; last_owner = 1 (so the CPU is favoured first);
  - an in-flight transaction is abandoned with no ack.

## Timing

- Request seen in IDLE at cycle 0:
  - ACCESS in cycles 1..MEM_LAT;
  - ack in cycle MEM_LAT+1.
- Read data is valid on rdata in the ack cycle and holds until that requester's next read completes.
- Handshake:
  - A requester keeps req/we/addr/wdata stable until it sees ack.
  - At the edge ending RESP, the requester either drops req or presents its next request. IDLE samples the updated value.
- Minimum transaction period is MEM_LAT+2 cycles (one IDLE cycle between transactions).
- cnt is 4 bits wide. MEM_LAT = 1 gives exactly one ACCESS cycle, carrying both mem_en and mem_we.

## Configuration

- MEM_ARB_RR_EN defined: round-robin arbitration. On a tie, the requester != last_owner wins; two continuously requesting masters alternate CPU, DMA, CPU…
- MEM_ARB_RR_EN undefined: fixed priority. The CPU always wins a tie, so a continuously requesting CPU starves DMA. last_owner is still maintained but unused.

## Test plan

- Reset: hold rst_n low with both reqs high → all outputs 0, owner = 0. Release → first grant goes to CPU in both configurations.
- CPU read, MEM_LAT = 2, cpu_addr = 0x3000, mem_rdata = 0x1234:
  - mem_en high in cycles 1–2 with mem_addr = 0x3000, mem_we = 0;
  - cpu_ack in cycle 3; cpu_rdata = 0x1234; dma_ack = 0 throughout.
- DMA write, dma_addr = 0x4000, dma_wdata = 0xBEEF:
  - mem_we high only in cycle 2;
  - dma_ack in cycle 3; dma_rdata unchanged; owner = 1.
- Both reqs held for 4 transactions:
  - with MEM_ARB_RR_EN, ack order is CPU, DMA, CPU, DMA;
  - without it, ack order is CPU ×4.
- rst_n pulsed low during ACCESS cycle 1 of a CPU write → mem_en/mem_we drop immediately, no cpu_ack, memory not written, FSM in IDLE after release.
- CPU re-requests on its ack edge (MEM_LAT = 2) → acks spaced exactly 4 cycles apart, with busy low for one cycle between transactions.
